// File: rtl/muldiv_ctrl.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide, mthi/mtlo writes.
// Optional MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle product.
module muldiv_ctrl (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START_MUL_E,
    input  logic        START_DIV_E,
    input  logic        SIGNED_E,
    input  logic [31:0] OP_A,
    input  logic [31:0] OP_B,
    input  logic        WRITE_HI_E,
    input  logic        WRITE_LO_E,
    input  logic        HILO_USE_D,
    output logic        BUSY,
    output logic        STALL,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic [31:0] opnd_reg, opnd_next;   // multiplicand or divisor magnitude
    logic [63:0] acc_reg, acc_next;     // product, or {remainder, quotient/dividend}
    logic        neg_lo_reg, neg_lo_next;
    logic        neg_hi_reg, neg_hi_next;
    logic        is_div_reg, is_div_next;
    logic        div_zero_reg, div_zero_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [31:0] div_sub;
    logic        div_ge;

    assign a_neg = SIGNED_E & OP_A[31];
    assign b_neg = SIGNED_E & OP_B[31];
    assign a_mag = a_neg ? -OP_A : OP_A;
    assign b_mag = b_neg ? -OP_B : OP_B;

    assign mul_sum   = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
    assign div_shift = {acc_reg[63:32], acc_reg[31]};
    assign div_ge    = div_shift >= {1'b0, opnd_reg};
    // When the subtract succeeds the true difference is below the divisor, so 32 bits suffice.
    assign div_sub   = div_shift[31:0] - opnd_reg;

    assign BUSY  = (state_reg != IDLE);
    assign STALL = HILO_USE_D & (BUSY | START_MUL_E | START_DIV_E);
    assign HI    = hi_reg;
    assign LO    = lo_reg;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg    <= IDLE;
            cnt_reg      <= 5'd0;
            opnd_reg     <= 32'd0;
            acc_reg      <= 64'd0;
            neg_lo_reg   <= 1'b0;
            neg_hi_reg   <= 1'b0;
            is_div_reg   <= 1'b0;
            div_zero_reg <= 1'b0;
            hi_reg       <= 32'd0;
            lo_reg       <= 32'd0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            opnd_reg     <= opnd_next;
            acc_reg      <= acc_next;
            neg_lo_reg   <= neg_lo_next;
            neg_hi_reg   <= neg_hi_next;
            is_div_reg   <= is_div_next;
            div_zero_reg <= div_zero_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        opnd_next     = opnd_reg;
        acc_next      = acc_reg;
        neg_lo_next   = neg_lo_reg;
        neg_hi_next   = neg_hi_reg;
        is_div_next   = is_div_reg;
        div_zero_next = div_zero_reg;
        hi_next       = hi_reg;
        lo_next       = lo_reg;

        case (state_reg)
            IDLE: begin
                if (START_MUL_E) begin
                    neg_lo_next   = a_neg ^ b_neg;
                    neg_hi_next   = a_neg ^ b_neg;
                    is_div_next   = 1'b0;
                    div_zero_next = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
                    acc_next      = {32'd0, a_mag} * {32'd0, b_mag};
                    cnt_next      = 5'd0;
                    state_next    = FIX;
`else
                    opnd_next     = a_mag;
                    acc_next      = {32'd0, b_mag};
                    cnt_next      = 5'd31;
                    state_next    = MUL;
`endif
                end else if (START_DIV_E) begin
                    opnd_next     = b_mag;
                    acc_next      = {32'd0, a_mag};
                    neg_lo_next   = a_neg ^ b_neg;
                    neg_hi_next   = a_neg;
                    is_div_next   = 1'b1;
                    div_zero_next = (OP_B == 32'd0);
                    cnt_next      = 5'd31;
                    state_next    = DIV;
                end else begin
                    if (WRITE_HI_E) hi_next = OP_A;
                    if (WRITE_LO_E) lo_next = OP_A;
                end
            end
            MUL: begin
                acc_next = {mul_sum, acc_reg[31:1]};
                if (cnt_reg == 5'd0) state_next = FIX;
                else                 cnt_next   = cnt_reg - 5'd1;
            end
            DIV: begin
                if (div_ge) acc_next = {div_sub,          acc_reg[30:0], 1'b1};
                else        acc_next = {div_shift[31:0],  acc_reg[30:0], 1'b0};
                if (cnt_reg == 5'd0) state_next = FIX;
                else                 cnt_next   = cnt_reg - 5'd1;
            end
            FIX: begin
                if (is_div_reg) begin
                    // Quotient of all ones on divide-by-zero; remainder then equals the dividend.
                    lo_next = div_zero_reg ? 32'hFFFF_FFFF
                                           : (neg_lo_reg ? -acc_reg[31:0] : acc_reg[31:0]);
                    hi_next = neg_hi_reg ? -acc_reg[63:32] : acc_reg[63:32];
                end else begin
                    {hi_next, lo_next} = neg_lo_reg ? -acc_reg : acc_reg;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected HI/LO queued at issue, popped when the unit goes idle.
module tb_muldiv_ctrl;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        START_MUL_E, START_DIV_E, SIGNED_E;
    logic [31:0] OP_A, OP_B;
    logic        WRITE_HI_E, WRITE_LO_E, HILO_USE_D;
    logic        BUSY, STALL;
    logic [31:0] HI, LO;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [31:0] hi_m, lo_m;

    muldiv_ctrl dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .START_MUL_E(START_MUL_E), .START_DIV_E(START_DIV_E), .SIGNED_E(SIGNED_E),
        .OP_A(OP_A), .OP_B(OP_B),
        .WRITE_HI_E(WRITE_HI_E), .WRITE_LO_E(WRITE_LO_E), .HILO_USE_D(HILO_USE_D),
        .BUSY(BUSY), .STALL(STALL), .HI(HI), .LO(LO)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    function automatic logic [63:0] model(input bit is_div, input bit sgn,
                                          input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, p, q, r;
        sa = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        sb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        if (!is_div) begin
            p = sa * sb;
            return p;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic do_write(input string tag, input bit wh, input bit wl, input logic [31:0] v);
        @(negedge CLK);
        exp_q.push_back({wh ? v : hi_m, wl ? v : lo_m});
        WRITE_HI_E = wh; WRITE_LO_E = wl; OP_A = v;
        @(negedge CLK);
        WRITE_HI_E = 1'b0; WRITE_LO_E = 1'b0;
        {hi_m, lo_m} = exp_q.pop_front();
        chk(tag, {HI, LO}, {hi_m, lo_m});
    endtask

    task automatic run_op(input string tag, input bit is_div, input bit sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit use_d, input bit intrude);
        int n, stalls, lat;
        logic [63:0] e;
        lat = is_div ? DIV_LAT : MUL_LAT;
        @(negedge CLK);
        START_MUL_E = !is_div; START_DIV_E = is_div; SIGNED_E = sgn;
        OP_A = a; OP_B = b; HILO_USE_D = use_d; WRITE_HI_E = intrude;
        exp_q.push_back(model(is_div, sgn, a, b));
        #1 stalls = (use_d && STALL) ? 1 : 0;
        @(negedge CLK);
        START_MUL_E = 1'b0; START_DIV_E = 1'b0; WRITE_HI_E = 1'b0;
        OP_A = 32'hDEAD_BEEF; OP_B = 32'h5555_AAAA;
        #1;
        if (lat > 2) chk({tag, "_start_hold"}, {HI, LO}, {hi_m, lo_m});
        n = 1;
        while (BUSY && n < 60) begin
            if (use_d && STALL) stalls++;
            if (intrude && n == 5) begin
                WRITE_HI_E = 1'b1; WRITE_LO_E = 1'b1; START_MUL_E = 1'b1; START_DIV_E = 1'b1;
                OP_A = 32'h0BAD_F00D;
            end
            @(negedge CLK);
            WRITE_HI_E = 1'b0; WRITE_LO_E = 1'b0; START_MUL_E = 1'b0; START_DIV_E = 1'b0;
            #1;
            if (intrude && n == 5) chk({tag, "_busy_hold"}, {HI, LO}, {hi_m, lo_m});
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(lat));
        if (use_d) begin
            chk({tag, "_stall_cycles"}, 64'(stalls), 64'(lat));
            chk({tag, "_stall_after"}, 64'(STALL), 64'd0);
        end
        e = exp_q.pop_front();
        chk({tag, "_hilo"}, {HI, LO}, e);
        {hi_m, lo_m} = e;
        HILO_USE_D = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b0;
        START_MUL_E = 1'b0; START_DIV_E = 1'b0; SIGNED_E = 1'b0;
        OP_A = 32'd0; OP_B = 32'd0;
        WRITE_HI_E = 1'b0; WRITE_LO_E = 1'b0; HILO_USE_D = 1'b1;
        hi_m = 32'd0; lo_m = 32'd0;
        #12;
        chk("reset_hilo", {HI, LO}, 64'd0);
        chk("reset_busy", 64'(BUSY), 64'd0);
        chk("reset_stall", 64'(STALL), 64'd0);
        @(negedge CLK);
        RESET_N = 1'b1; HILO_USE_D = 1'b0;

        do_write("mthi", 1'b1, 1'b0, 32'h0000_1234);
        do_write("mtlo", 1'b0, 1'b1, 32'h0000_5678);
        do_write("mthi_mtlo", 1'b1, 1'b1, 32'hCAFE_F00D);

        run_op("multu_max",  0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op("mult_neg",   0, 1, -32'sd3,        32'd5,         0, 0);
        run_op("mult_minsq", 0, 1, 32'h8000_0000, 32'h8000_0000, 0, 0);
        run_op("div_m7_2",   1, 1, -32'sd7,        32'd2,         1, 0);
        run_op("divu_zero",  1, 0, 32'd100,        32'd0,         0, 0);
        run_op("div_ovf",    1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op("div_7_m2",   1, 1, 32'd7,          -32'sd2,       0, 1);
        run_op("div_szero",  1, 1, -32'sd5,        32'd0,         0, 0);
        run_op("multu_stall",0, 0, 32'h0001_0003, 32'h0002_0005, 1, 0);
        for (int i = 0; i < 4; i++)
            run_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 9)) : $urandom, 0, 0);

        // Abort a multiply mid-flight with reset, then start again on the first edge after release.
        @(negedge CLK);
        START_MUL_E = 1'b1; SIGNED_E = 1'b0; OP_A = 32'h0123_4567; OP_B = 32'h89AB_CDEF;
        @(negedge CLK);
        START_MUL_E = 1'b0;
        repeat (10) @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        chk("abort_hilo", {HI, LO}, 64'd0);
        chk("abort_busy", 64'(BUSY), 64'd0);
        hi_m = 32'd0; lo_m = 32'd0;
        @(posedge CLK);
        #2 RESET_N = 1'b1;
        run_op("mult_3x5", 0, 0, 32'd3, 32'd5, 0, 0);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
